// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op codes, FSM state type and reserved-op defaults for alu_seq
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_INC  = 4'd6,
        OP_DEC  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_PASS = 4'd10,
        OP_MUL  = 4'd11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic z;
        logic cout;
        logic n;
        logic v;
    } flags_t;

    // Reserved ops report a zero result, so only the zero flag is set.
    localparam flags_t RESERVED_FLAGS = '{z: 1'b1, cout: 1'b0, n: 1'b0, v: 1'b0};

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add unsigned multiplier, one iteration per clock
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [2*WIDTH-1:0] src;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     hi_sum;

    // One shift-add iteration; the load cycle already performs the first one
    // on the incoming operands so WIDTH iterations finish in WIDTH clocks.
    always_comb begin
        src     = load ? {{WIDTH{1'b0}}, b} : prod_q;
        addend  = load ? a : mcand_q;
        hi_sum  = {1'b0, src[2*WIDTH-1:WIDTH]} + (src[0] ? {1'b0, addend} : '0);
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (load) begin
            mcand_d = a;
            prod_d  = {hi_sum, src[WIDTH-1:1]};
            cnt_d   = CW'(1);
        end else if (step) begin
            prod_d  = {hi_sum, src[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = prod_q;
    assign last    = (cnt_q == CNT_LAST);

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle ops plus iterative multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] d_hi,
    output logic             z,
    output logic             cout,
    output logic             n,
    output logic             v
);

    localparam int M = WIDTH - 1;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] d_hi_q, d_hi_d;
    flags_t           flags_q, flags_d;

    logic [WIDTH-1:0]   alu_res;
    flags_t             alu_flags;
    logic [WIDTH:0]     ext;
    logic               reserved;
    op_e                op_sel;

    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] mul_product;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a       (a),
        .b       (b),
        .product (mul_product),
        .last    (mul_last)
    );

    // Single-cycle datapath, evaluated on the live operands at start.
    always_comb begin
        op_sel    = op_e'(op);
        ext       = '0;
        alu_res   = '0;
        alu_flags = '0;
        reserved  = 1'b0;
        case (op_sel)
            OP_ADD: begin
                ext            = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                alu_res        = ext[M:0];
                alu_flags.cout = ext[WIDTH];
                alu_flags.v    = (a[M] == b[M]) && (alu_res[M] != a[M]);
            end
            OP_SUB: begin
                ext            = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
                alu_res        = ext[M:0];
                alu_flags.cout = ext[WIDTH];
                alu_flags.v    = (a[M] != b[M]) && (alu_res[M] != a[M]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_INC: begin
                ext            = {1'b0, a} + (WIDTH+1)'(1);
                alu_res        = ext[M:0];
                alu_flags.cout = ext[WIDTH];
                alu_flags.v    = !a[M] && alu_res[M];
            end
            OP_DEC: begin
                ext            = {1'b0, a} - (WIDTH+1)'(1);
                alu_res        = ext[M:0];
                alu_flags.cout = ext[WIDTH];
                alu_flags.v    = a[M] && !alu_res[M];
            end
            OP_SHL: begin
                alu_res        = {a[M-1:0], cin};
                alu_flags.cout = a[M];
            end
            OP_SHR: begin
                alu_res        = {cin, a[M:1]};
                alu_flags.cout = a[0];
            end
            OP_PASS: alu_res = b;
            default: begin
                reserved  = 1'b1;
                alu_res   = '0;
                alu_flags = RESERVED_FLAGS;
            end
        endcase
        if (!reserved) begin
            alu_flags.z = (alu_res == '0);
            alu_flags.n = alu_res[M];
        end
    end

    // Sequencer next state: single-cycle ops finish in IDLE, MUL iterates until last.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        d_d      = d_q;
        d_hi_d   = d_hi_q;
        flags_d  = flags_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_e'(op) == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                        busy_d   = 1'b1;
                    end else begin
                        d_d     = alu_res;
                        d_hi_d  = '0;
                        flags_d = alu_flags;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    d_d          = mul_product[M:0];
                    d_hi_d       = mul_product[2*WIDTH-1:WIDTH];
                    flags_d.z    = (mul_product == '0);
                    flags_d.n    = mul_product[2*WIDTH-1];
                    flags_d.cout = (mul_product[2*WIDTH-1:WIDTH] != '0);
                    flags_d.v    = 1'b0;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    mul_step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            d_hi_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            d_hi_q  <= d_hi_d;
            flags_q <= flags_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign d_hi = d_hi_q;
    assign z    = flags_q.z;
    assign cout = flags_q.cout;
    assign n    = flags_q.n;
    assign v    = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       cin = 1'b0;
    logic       busy, done, z, cout, n, v;
    logic [7:0] d, d_hi;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int d;
        int dh;
        int z;
        int c;
        int n;
        int v;
    } exp_t;

    exp_t last_exp;

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .d_hi  (d_hi),
        .z     (z),
        .cout  (cout),
        .n     (n),
        .v     (v)
    );

    always #5 clk = ~clk;

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic int ovf(input int s);
        return (s > 127 || s < -128) ? 1 : 0;
    endfunction

    // Reference: plain integer arithmetic on 8-bit operands.
    function automatic exp_t model(input int o, input int x, input int y, input int ci);
        exp_t e;
        int r;
        int p;
        e = '{default: 0};
        r = 0;
        case (o)
            0:  begin r = x + y + ci; e.c = int'(r > 255); e.v = ovf(sgn(x) + sgn(y) + ci); end
            1:  begin r = x - y - ci; e.c = int'(r < 0);   e.v = ovf(sgn(x) - sgn(y) - ci); end
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = 255 - x;
            6:  begin r = x + 1; e.c = int'(r > 255); e.v = ovf(sgn(x) + 1); end
            7:  begin r = x - 1; e.c = int'(r < 0);   e.v = ovf(sgn(x) - 1); end
            8:  begin r = x * 2 + ci; e.c = x / 128; end
            9:  begin r = ci * 128 + x / 2; e.c = x % 2; end
            10: r = y;
            11: begin p = x * y; r = p; e.dh = p / 256; e.c = int'(e.dh != 0); end
            default: r = 0;
        endcase
        e.d = r & 255;
        if (o == 11) begin
            e.z = int'(x * y == 0);
            e.n = int'(e.dh >= 128);
        end else begin
            e.z = int'(e.d == 0);
            e.n = int'(e.d >= 128);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e);
        check({tag, ".d"},    32'(d),    32'(e.d));
        check({tag, ".d_hi"}, 32'(d_hi), 32'(e.dh));
        check({tag, ".z"},    32'(z),    32'(e.z));
        check({tag, ".cout"}, 32'(cout), 32'(e.c));
        check({tag, ".n"},    32'(n),    32'(e.n));
        check({tag, ".v"},    32'(v),    32'(e.v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a single-cycle op for one edge; start is left high for back-to-back use.
    task automatic apply(input string tag, input int o, input int x, input int y, input int ci);
        op = 4'(o); a = 8'(x); b = 8'(y); cin = 1'(ci); start = 1'b1;
        last_exp = model(o, x, y, ci);
        tick();
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check_result(tag, last_exp);
    endtask

    task automatic idle_hold(input string tag);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        tick();
        check({tag, ".done_low"}, 32'(done), 32'd0);
        check_result({tag, ".hold"}, last_exp);
    endtask

    // MUL with an ignored ADD start injected at the third edge after the start edge.
    task automatic run_mul(input string tag, input int x, input int y);
        int busy_cycles;
        int done_at;
        op = 4'd11; a = 8'(x); b = 8'(y); cin = 1'b0; start = 1'b1;
        last_exp = model(11, x, y, 0);
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        busy_cycles = 0;
        done_at = -1;
        if (busy === 1'b1) busy_cycles++;
        check({tag, ".done_early"}, 32'(done), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                op = 4'd0; start = 1'b1; a = 8'h11; b = 8'h22;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
        end
        start = 1'b0;
        check({tag, ".done_edge"}, 32'(done_at), 32'd8);
        check({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd8);
        check({tag, ".busy_drop"}, 32'(busy), 32'd0);
        check_result(tag, last_exp);
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int o, x, y, ci;
        int saw_done;

        // Reset state, with start held high to show reset priority.
        rst = 1'b1; start = 1'b1; op = 4'd0; a = 8'h12; b = 8'h34;
        tick();
        tick();
        last_exp = '{default: 0};
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_result("rst", last_exp);
        start = 1'b0;
        rst = 1'b0;
        tick();

        // Directed cases.
        apply("add_3_4_c1", 0, 8'h03, 8'h04, 1);
        idle_hold("add_3_4_c1");
        apply("sub_3_4", 1, 8'h03, 8'h04, 0);
        idle_hold("sub_3_4");
        apply("inc_ff", 6, 8'hFF, 8'h00, 0);
        idle_hold("inc_ff");
        apply("add_7f_1", 0, 8'h7F, 8'h01, 0);
        idle_hold("add_7f_1");
        apply("shl_81", 8, 8'h81, 8'h00, 1);
        idle_hold("shl_81");
        apply("op13", 13, 8'h5A, 8'hA5, 1);
        idle_hold("op13");
        run_mul("mul_ff_ff", 8'hFF, 8'hFF);
        run_mul("mul_0_37", 8'h00, 8'h37);

        // Back-to-back single-cycle ops: one done per start.
        apply("b2b0", 4, 8'hF0, 8'h3C, 0);
        apply("b2b1", 9, 8'h01, 8'h00, 1);
        apply("b2b2", 7, 8'h00, 8'h00, 0);
        apply("b2b3", 1, 8'h80, 8'h01, 0);
        idle_hold("b2b");

        // Randomized ops against the model.
        for (int k = 0; k < 60; k++) begin
            o = int'($urandom_range(0, 15));
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            ci = int'($urandom_range(0, 1));
            if (o == 11) run_mul("rnd_mul", x, y);
            else apply("rnd", o, x, y, ci);
        end
        idle_hold("rnd");

        // Reset in the middle of a MUL aborts it with no done.
        op = 4'd11; a = 8'hC3; b = 8'h5D; start = 1'b1;
        tick();
        start = 1'b0;
        saw_done = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        rst = 1'b1;
        tick();
        last_exp = '{default: 0};
        check("abort.done_seen", 32'(saw_done), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check_result("abort", last_exp);
        rst = 1'b0;
        apply("post_rst_add", 0, 8'h21, 8'h13, 1);
        idle_hold("post_rst_add");
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        check("abort.no_late_done", 32'(saw_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand and result width (legal range 4..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request an operation, sampled only in IDLE.
REQ-005 op  input  4  SHALL select the operation, sampled with start.
REQ-006 a, b  input  WIDTH  SHALL be the operands, sampled with start.
REQ-007 cin  input  1  SHALL be the carry/borrow/shift-in bit, sampled with start.
REQ-008 busy  output  1  SHALL be high while a multi-cycle operation runs.
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when a result is updated.
REQ-010 d  output  WIDTH  SHALL carry the result, or the low half for MUL.
REQ-011 d_hi  output  WIDTH  SHALL carry the MUL high half; 0 for all other ops.
REQ-012 z, cout, n, v  output  1 each  SHALL be the zero, carry/borrow, negative and signed-overflow flags.

Function
REQ-013 Op encoding SHALL be: 0 ADD a+b+cin; 1 SUB a-b-cin; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 INC a; 7 DEC a; 8 SHL a, cin into LSB; 9 SHR a, cin into MSB; 10 PASS b; 11 MUL unsigned a*b; 12-15 reserved.
REQ-014 FSM SHALL have states IDLE and MUL; single-cycle ops never leave IDLE.
REQ-015 Single-cycle op: start at edge t SHALL register d and flags at edge t, with done high during cycle t+1 (latency 1).
REQ-016 MUL: start at edge t SHALL enter MUL with busy=1, run WIDTH shift-add iterations (one per clock), return to IDLE, and update d, d_hi and flags with done high exactly WIDTH+1 cycles after t; busy SHALL drop in the same cycle done rises.
REQ-017 start while busy=1 SHALL be ignored without side effects; operands SHALL be latched internally at start.
REQ-018 d, d_hi and flags SHALL hold their value between done pulses.
REQ-019 z SHALL be 1 iff d==0 (for MUL, iff {d_hi,d}==0); n SHALL equal d[WIDTH-1] (d_hi[WIDTH-1] for MUL).
REQ-020 cout SHALL be the carry out for ADD/INC, 1 on borrow for SUB/DEC, the bit shifted out for SHL/SHR, 1 iff d_hi!=0 for MUL, and 0 otherwise.
REQ-021 v SHALL be the two's-complement overflow for ADD/SUB/INC/DEC and 0 otherwise.
REQ-022 Arithmetic SHALL be computed WIDTH+1 bits wide internally; results SHALL wrap modulo 2^WIDTH.
REQ-023 A reserved op SHALL complete in 1 cycle with d=0, d_hi=0, z=1 and the other flags 0.

Reset
REQ-024 While rst=1, the block SHALL go to IDLE with busy=0, done=0, d=0, d_hi=0 and z=cout=n=v=0; rst takes priority over start.
REQ-025 rst asserted during MUL SHALL abort the operation with no done pulse; the block SHALL accept start on the first cycle after rst deasserts.

Structure
REQ-026 Op codes, the FSM state type and the reserved-op default SHALL reside in a shared package, alu_seq_pkg.
REQ-027 The iterative multiplier SHALL be a sub-module, alu_seq_mul (load, step, product, last), instantiated once.

Verification (WIDTH=8)
REQ-028 a=0x03, b=0x04, cin=1, op=ADD -> done at t+1, d=0x08, z=0, cout=0, n=0, v=0.
REQ-029 a=0x03, b=0x04, cin=0, op=SUB -> d=0xFF, cout=1, n=1, v=0; op=INC with a=0xFF -> d=0x00, z=1, cout=1.
REQ-030 a=0xFF, b=0xFF, op=MUL -> busy for 8 cycles, done at t+9, d=0x01, d_hi=0xFE, cout=1; a second start at t+3 (op=ADD) is ignored.
REQ-031 a=0x7F, b=0x01, cin=0, op=ADD -> d=0x80, v=1, n=1; op=SHL with a=0x81, cin=1 -> d=0x03, cout=1.
REQ-032 Start MUL, assert rst at t+4 -> no done, all outputs 0; start ADD on the first cycle after reset -> correct result at the next cycle.
REQ-033 op=13 -> d=0, z=1, done after 1 cycle; back-to-back starts of single-cycle ops on consecutive cycles -> one done per start.
